// File: rtl/dpipe_reg_if.sv
// Handshake bundle for dpipe_reg: producer side (in_*), consumer side (out_*), flush and occupancy.
// The slave modport is the pipeline's view; the master modport is the surrounding datapath's view.
interface dpipe_reg_if #(
   parameter int M = 32,
   parameter int N = 2
);
   localparam int CW = $clog2(N + 1);

   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [M-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [M-1:0]  out_data;
   logic [CW-1:0] count;

   modport master (
      output flush,
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  count
   );

   modport slave (
      input  flush,
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output count
   );
endinterface

// File: rtl/dpipe_reg.sv
// Elastic N-stage pipeline register with per-stage valid, bubble squeezing and synchronous flush.
// Latency N edges when unstalled; in_ready is the combinational ready chain, outputs come straight from flops.
module dpipe_reg #(
   parameter int M = 32,
   parameter int N = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   dpipe_reg_if.slave io_pipe
);
   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  r_v;
   logic [M-1:0]  r_d [N];
   logic [CW-1:0] r_count;

   logic [N:0]    w_rdy;
   logic [N-1:0]  w_up_v;
   logic [M-1:0]  w_up_d [N];
   logic [N-1:0]  w_v_nxt;
   logic [CW-1:0] w_count_nxt;

   // A stage can take new data if it is empty or its own content moves on this edge.
   assign w_rdy[N]  = io_pipe.out_ready;
   assign w_up_v[0] = io_pipe.in_valid;
   assign w_up_d[0] = io_pipe.in_data;

   for (genvar gi = 0; gi < N; gi++) begin : g_stage
      assign w_rdy[gi] = ~r_v[gi] | w_rdy[gi+1];

      if (gi > 0) begin : g_link
         assign w_up_v[gi] = r_v[gi-1];
         assign w_up_d[gi] = r_d[gi-1];
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_d[gi] <= '0;
         end else if (!io_pipe.flush && w_rdy[gi] && w_up_v[gi]) begin
            r_d[gi] <= w_up_d[gi];
         end
      end
   end

   always_comb begin
      w_v_nxt     = r_v;
      w_count_nxt = '0;
      for (int i = 0; i < N; i++) begin
         if (io_pipe.flush) begin
            w_v_nxt[i] = 1'b0;
         end else if (w_rdy[i]) begin
            w_v_nxt[i] = w_up_v[i];
         end
         w_count_nxt = w_count_nxt + CW'(w_v_nxt[i]);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_v     <= '0;
         r_count <= '0;
      end else begin
         r_v     <= w_v_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign io_pipe.in_ready  = w_rdy[0] & ~io_pipe.flush;
   assign io_pipe.out_valid = r_v[N-1];
   assign io_pipe.out_data  = r_d[N-1];
   assign io_pipe.count     = r_count;

   a_count_matches_valids: assert property (
      @(posedge i_clk) disable iff (i_rst)
      r_count == CW'($countones(r_v))
   );

   // A stalled head item must be presented unchanged until it is taken.
   a_stall_holds_head: assert property (
      @(posedge i_clk) disable iff (i_rst)
      (r_v[N-1] && !io_pipe.out_ready && !io_pipe.flush) |=> (r_v[N-1] && $stable(r_d[N-1]))
   );
endmodule
